// File: rtl/div_issue_ctrl_pkg.sv
// Shared divider defines: DIV_OP encodings, op width and one-hot state bits.
// Used by div_issue_ctrl and div_fastpath. Optional feature macro in this
// slice: DIV_RESULT_CACHE_EN (one-entry result cache in div_issue_ctrl).
package div_issue_ctrl_pkg;

  localparam int DIV_OP_WIDTH = 2;

  // bit0 = unsigned, bit1 = remainder
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REM  = 2'b10;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REMU = 2'b11;

  localparam int ST_IDLE_BIT = 0;
  localparam int ST_WAIT_BIT = 1;
  localparam int ST_COMP_BIT = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001 << ST_IDLE_BIT,
    ST_WAIT = 3'b001 << ST_WAIT_BIT,
    ST_COMP = 3'b001 << ST_COMP_BIT
  } div_state_e;

  function automatic logic op_is_signed(input logic [DIV_OP_WIDTH-1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [DIV_OP_WIDTH-1:0] op);
    return op[1];
  endfunction

  // DIV<->REM, DIVU<->REMU
  function automatic logic [DIV_OP_WIDTH-1:0] op_companion(input logic [DIV_OP_WIDTH-1:0] op);
    return {~op[1], op[0]};
  endfunction

endpackage

// File: rtl/div_issue_ctrl_fastpath.sv
// div_fastpath: combinational detection of the two divide cases that need no
// divider iteration (divide by zero, signed INT_MIN / -1) and their results.
module div_fastpath #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              signed_op,
  output logic              is_zero,
  output logic              is_ovf,
  output logic [DATA_W-1:0] fast_quot,
  output logic [DATA_W-1:0] fast_rem
);

  localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Zero divisor wins over overflow; both return architectural results.
  always_comb begin
    is_zero   = (divisor == '0);
    is_ovf    = signed_op && (dividend == INT_MIN) && (divisor == '1) && !is_zero;
    fast_quot = is_zero ? '1 : INT_MIN;
    fast_rem  = is_zero ? dividend : '0;
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: accepts a CPU divide request, resolves special cases
// locally, otherwise issues the external p23_divider and returns the result.
// After the primary result the companion op is presented so the divider's
// other result can be captured. Optional: DIV_RESULT_CACHE_EN adds a
// one-entry {dividend, divisor, signed, quotient, remainder} result cache.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_W-1:0]       divident,
  input  logic [DATA_W-1:0]       divisor,
  input  logic [DIV_OP_WIDTH-1:0] DIVop,
  input  logic                    valid,
  output logic                    ready,
  output logic [DATA_W-1:0]       rslt,
  output logic                    div_by_zero,
  output logic [DATA_W-1:0]       div_divident,
  output logic [DATA_W-1:0]       div_divisor,
  output logic [DIV_OP_WIDTH-1:0] div_DIVop,
  output logic                    div_valid,
  input  logic                    div_ready,
  input  logic [DATA_W-1:0]       div_rslt
);

  div_state_e              state_q;
  logic                    ready_q;
  logic [DATA_W-1:0]       rslt_q;
  logic                    dbz_q;
  logic                    div_valid_q;
  logic [DATA_W-1:0]       div_a_q;
  logic [DATA_W-1:0]       div_b_q;
  logic [DIV_OP_WIDTH-1:0] div_op_q;

  logic              fp_zero, fp_ovf;
  logic [DATA_W-1:0] fp_quot, fp_rem;
  logic              cache_hit;
  logic [DATA_W-1:0] cache_rslt;

  div_fastpath #(.DATA_W(DATA_W)) u_fastpath (
    .dividend  (divident),
    .divisor   (divisor),
    .signed_op (op_is_signed(DIVop)),
    .is_zero   (fp_zero),
    .is_ovf    (fp_ovf),
    .fast_quot (fp_quot),
    .fast_rem  (fp_rem)
  );

`ifdef DIV_RESULT_CACHE_EN
  logic              c_vld_q;
  logic [DATA_W-1:0] c_a_q, c_b_q, c_quot_q, c_rem_q;
  logic              c_sgn_q;

  // Lookup against the incoming request operands.
  always_comb begin
    cache_hit  = c_vld_q && (c_a_q == divident) && (c_b_q == divisor) &&
                 (c_sgn_q == op_is_signed(DIVop));
    cache_rslt = op_is_rem(DIVop) ? c_rem_q : c_quot_q;
  end

  // Fill in COMP: div_op_q already holds the companion op, so a REM
  // companion means rslt_q is the quotient and div_rslt the remainder.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      c_vld_q  <= 1'b0;
      c_a_q    <= '0;
      c_b_q    <= '0;
      c_sgn_q  <= 1'b0;
      c_quot_q <= '0;
      c_rem_q  <= '0;
    end else if (state_q == ST_COMP) begin
      c_vld_q  <= 1'b1;
      c_a_q    <= div_a_q;
      c_b_q    <= div_b_q;
      c_sgn_q  <= op_is_signed(div_op_q);
      c_quot_q <= op_is_rem(div_op_q) ? rslt_q : div_rslt;
      c_rem_q  <= op_is_rem(div_op_q) ? div_rslt : rslt_q;
    end
  end
`else
  // No storage: the companion value seen in COMP is simply dropped.
  always_comb begin
    cache_hit  = 1'b0;
    cache_rslt = '0;
  end
`endif

  // Issue FSM with registered handshake, result and divider-side outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      rslt_q      <= '0;
      dbz_q       <= 1'b0;
      div_valid_q <= 1'b0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      div_op_q    <= '0;
    end else begin
      ready_q <= 1'b0;
      dbz_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // ready_q high here means a result was just returned: skip a cycle.
          if (valid && !ready_q) begin
            div_a_q  <= divident;
            div_b_q  <= divisor;
            div_op_q <= DIVop;
            if (fp_zero || fp_ovf) begin
              ready_q <= 1'b1;
              rslt_q  <= op_is_rem(DIVop) ? fp_rem : fp_quot;
              dbz_q   <= fp_zero;
            end else if (cache_hit) begin
              ready_q <= 1'b1;
              rslt_q  <= cache_rslt;
            end else begin
              div_valid_q <= 1'b1;
              state_q     <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (div_ready) begin
            rslt_q      <= div_rslt;
            div_valid_q <= 1'b0;
            div_op_q    <= op_companion(div_op_q);
            ready_q     <= 1'b1;
            state_q     <= ST_COMP;
          end
        end
        ST_COMP: state_q <= ST_IDLE;
        default: begin
          state_q     <= ST_IDLE;
          div_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready        = ready_q;
  assign rslt         = rslt_q;
  assign div_by_zero  = dbz_q;
  assign div_valid    = div_valid_q;
  assign div_divident = div_a_q;
  assign div_divisor  = div_b_q;
  assign div_DIVop    = div_op_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural divider model on the downstream port,
// directed cases followed by randomized requests against a reference model.
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

`ifdef DIV_RESULT_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] divident, divisor;
  logic [1:0]  DIVop;
  logic        valid;
  logic        ready;
  logic [31:0] rslt;
  logic        div_by_zero;
  logic [31:0] div_divident, div_divisor;
  logic [1:0]  div_DIVop;
  logic        div_valid;
  logic        div_ready;
  logic [31:0] div_rslt;

  int tests = 0;
  int fails = 0;

  div_issue_ctrl #(.DATA_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .divident     (divident),
    .divisor      (divisor),
    .DIVop        (DIVop),
    .valid        (valid),
    .ready        (ready),
    .rslt         (rslt),
    .div_by_zero  (div_by_zero),
    .div_divident (div_divident),
    .div_divisor  (div_divisor),
    .div_DIVop    (div_DIVop),
    .div_valid    (div_valid),
    .div_ready    (div_ready),
    .div_rslt     (div_rslt)
  );

  always #5 clk = ~clk;

  // RISC-V M-extension division semantics, including the special cases.
  function automatic logic [31:0] ref_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    logic sg;
    sg = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (sg) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return ((op == DIV_OP_REM) || (op == DIV_OP_REMU)) ? r : q;
  endfunction

  // Downstream divider: latches operands on div_valid, answers after dv_lat
  // cycles with a one-cycle div_ready; result follows div_DIVop.
  int          dv_lat = 4;
  int          issues = 0;
  logic        dv_busy;
  int          dv_cnt;
  logic [31:0] dv_a, dv_b;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dv_busy   <= 1'b0;
      dv_cnt    <= 0;
      div_ready <= 1'b0;
      dv_a      <= 32'd0;
      dv_b      <= 32'd0;
    end else begin
      div_ready <= 1'b0;
      if (dv_busy) begin
        if (dv_cnt <= 1) begin
          div_ready <= 1'b1;
          dv_busy   <= 1'b0;
        end else begin
          dv_cnt <= dv_cnt - 1;
        end
      end else if (div_valid && !div_ready) begin
        dv_busy <= 1'b1;
        dv_cnt  <= dv_lat;
        dv_a    <= div_divident;
        dv_b    <= div_divisor;
        issues  <= issues + 1;
      end
    end
  end

  assign div_rslt = ref_calc(div_DIVop, dv_a, dv_b);

  // Expected cache contents: operands of the last completed divider issue.
  bit          c_vld = 1'b0;
  logic [31:0] c_a, c_b;
  bit          c_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request from a negedge; returns on the negedge after the ready pulse.
  task automatic do_req(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input bit exp_dbz);
    int cyc;
    int iss0;
    bit saw_dv, overlap, sg, fast, hit, issue_exp;
    sg        = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    fast      = (b == 32'd0) || (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    hit       = CACHE_EN && c_vld && c_a == a && c_b == b && c_s == sg;
    issue_exp = !fast && !hit;
    iss0      = issues;
    divident = a; divisor = b; DIVop = op; valid = 1'b1;
    cyc = 0; saw_dv = 1'b0; overlap = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (div_valid) saw_dv = 1'b1;
      if (div_valid && ready) overlap = 1'b1;
    end while (!ready && cyc < 300);
    valid = 1'b0;
    check({tag, " ready"}, ready, 1'b1);
    check({tag, " rslt"}, rslt, exp_r);
    check({tag, " div_by_zero"}, div_by_zero, exp_dbz);
    check({tag, " issued"}, (issues != iss0), issue_exp);
    check({tag, " div_valid&ready"}, overlap, 1'b0);
    if (!issue_exp) begin
      check({tag, " latency"}, cyc, 1);
      check({tag, " div_valid seen"}, saw_dv, 1'b0);
    end
    @(negedge clk);
    check({tag, " single ready"}, ready, 1'b0);
    check({tag, " div_valid idle"}, div_valid, 1'b0);
    if (issue_exp) begin
      c_vld = 1'b1; c_a = a; c_b = b; c_s = sg;
    end
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b, pa, pb;
    resetn = 1'b0; valid = 1'b0; divident = '0; divisor = '0; DIVop = '0;
    pa = 32'd1; pb = 32'd1;
    @(negedge clk); @(negedge clk);
    check("reset ready", ready, 1'b0);
    check("reset rslt", rslt, 32'd0);
    check("reset div_by_zero", div_by_zero, 1'b0);
    check("reset div_valid", div_valid, 1'b0);
    check("reset div_divident", div_divident, 32'd0);
    check("reset div_divisor", div_divisor, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    do_req("divu 100/7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
    do_req("div -100/7", DIV_OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0);
    do_req("rem -100/7", DIV_OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b0);
    do_req("div 5/0", DIV_OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    do_req("rem ovf", DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    do_req("div ovf", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    do_req("divu 9/3 a", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0);
    do_req("remu 9/3", DIV_OP_REMU, 32'd9, 32'd3, 32'd0, 1'b0);

    // Abandon an issue 10 cycles into WAIT with an asynchronous reset.
    dv_lat = 30;
    divident = 32'd1000; divisor = 32'd7; DIVop = DIV_OP_DIVU; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    check("wait div_valid", div_valid, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("mid-wait reset ready", ready, 1'b0);
    check("mid-wait reset div_valid", div_valid, 1'b0);
    c_vld = 1'b0;
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    dv_lat = 5;
    @(negedge clk);
    do_req("divu 9/3 after reset", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0);

    // valid held high: fast-path acceptances every other cycle.
    divident = 32'd5; divisor = 32'd0; DIVop = DIV_OP_DIV; valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("hold ready %0d", i), ready, (i % 2 == 0));
      check($sformatf("hold div_valid %0d", i), div_valid, 1'b0);
    end
    valid = 1'b0;
    @(negedge clk);

    // Randomized requests, biased toward special cases and repeats.
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       begin a = $urandom; b = 32'd0; end
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2, 3:    begin a = pa; b = pb; end
        4, 5:    begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      dv_lat = $urandom_range(1, 8);
      do_req($sformatf("rand %0d", n), op, a, b, ref_calc(op, a, b), (b == 32'd0));
      pa = a; pb = b;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port: clk  in  1  single clock; all state is on its rising edge.
REQ-003 SHALL have port: resetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: divident  in  32  CPU dividend.
REQ-005 SHALL have port: divisor  in  32  CPU divisor.
REQ-006 SHALL have port: DIVop  in  DIV_OP_WIDTH  operation select: DIV, DIVU, REM or REMU.
REQ-007 SHALL have port: valid  in  1  request; held high until ready is seen.
REQ-008 SHALL have port: ready  out  1  one-cycle pulse; rslt is valid in that cycle.
REQ-009 SHALL have port: rslt  out  32  quotient or remainder.
REQ-010 SHALL have port: div_by_zero  out  1  registered flag, valid with ready.
REQ-011 SHALL have ports to the downstream p23_divider: div_divident/div_divisor out 32; div_DIVop out DIV_OP_WIDTH; div_valid out 1; div_ready in 1; div_rslt in 32.

Function
REQ-012 Request acceptance SHALL happen only when state is IDLE, valid=1 and ready=0; operands and op SHALL be latched on acceptance.
REQ-013 The states SHALL be IDLE, WAIT, COMP, with one-hot encoding.
REQ-014 Fast path (divisor==0): quotient=32'hFFFF_FFFF and remainder=dividend; ready=1 with div_by_zero=1 in the cycle after acceptance, then back to IDLE; the divider SHALL NOT be issued.
REQ-015 Fast path (signed op, dividend=32'h8000_0000, divisor=32'hFFFF_FFFF): quotient=32'h8000_0000, remainder=0; same 1-cycle latency.
REQ-016 Any other request SHALL go IDLE->WAIT, driving div_valid=1 and stable div_* operands and op from the cycle after acceptance until div_ready is sampled high.
REQ-017 In the cycle div_ready=1:
- rslt SHALL latch div_rslt;
- div_valid SHALL be driven 0 on the next edge;
- div_DIVop SHALL switch to the companion op (DIV<->REM, DIVU<->REMU);
- ready SHALL be set;
- state SHALL go to COMP.
REQ-018 In COMP, ready=1 for exactly that cycle, div_rslt (companion result) SHALL be captured, and state SHALL return to IDLE.
REQ-019 In IDLE, a valid that is high while ready=1 SHALL be ignored; no back-to-back acceptance is allowed.
REQ-020 div_valid SHALL never be high in IDLE or COMP, so the divider never restarts on its own ready pulse.
REQ-021 A fast-path or cache-hit request SHALL take priority over issue; fast-path checks SHALL take priority over a cache lookup.

Reset
REQ-022 On resetn=0, asynchronously: state=IDLE, ready=0, div_valid=0, rslt=0, div_by_zero=0, div_* operands=0, and the cache is invalidated.
REQ-023 A reset during WAIT SHALL abandon the operation.
- The next request SHALL re-issue.
- The divider shares resetn, so it is reset too.

Configuration
REQ-024 Macro DIV_RESULT_CACHE_EN defined: a one-entry cache SHALL hold {dividend, divisor, signed, quotient, remainder, valid}.
- It is filled in COMP.
- A request with equal dividend, divisor and signedness SHALL hit: ready in the cycle after acceptance, no divider issue.
REQ-025 Macro undefined: no cache storage; COMP still exists, but the captured companion value is discarded.

Structure
REQ-026 DIV_OP encodings, DIV_OP_WIDTH and the state-bit constants SHALL live in the shared riscv_defines header.
REQ-027 The special-case detection SHALL be a combinational sub-module div_fastpath.
- Outputs: is_zero, is_ovf, fast quotient, fast remainder.
- p23_divider SHALL be instantiated by the parent, not inside this block.

Verification
REQ-028 The bench SHALL cover:
- DIVU 100/7 -> div_valid pulse train; ready after divider completion; rslt=14; one ready pulse.
- REM 32'hFFFF_FF9C(-100)/7 issued after DIV with the same operands -> with the macro: ready the cycle after acceptance, rslt=32'hFFFF_FFFE, div_valid stays 0; without the macro: full issue, same rslt.
- DIV 5/0 -> ready next cycle, rslt=32'hFFFF_FFFF, div_by_zero=1, div_valid stays 0.
- REM 32'h8000_0000/32'hFFFF_FFFF -> ready next cycle, rslt=0; DIV of the same operands -> rslt=32'h8000_0000.
- resetn pulsed low 10 cycles into WAIT -> ready=0 and div_valid=0 immediately; a following DIVU 9/3 returns rslt=3 via a full issue (cache miss).
- valid held high through ready -> exactly one ready pulse per acceptance, with one idle cycle between consecutive acceptances.
